// File: rtl/adder_pkg.sv
// Shared types and constants for the bit-serial, mux-based adder.
// The two LUTs are the full-adder truth tables indexed by {a, b, carry}.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] SUM_LUT   = 8'b1001_0110;
    localparam logic [7:0] CARRY_LUT = 8'b1110_1000;

    // Position of each operand bit inside the 3-bit mux select.
    localparam int SEL_A_BIT = 2;
    localparam int SEL_B_BIT = 1;
    localparam int SEL_C_BIT = 0;

    function automatic logic [2:0] make_sel(input logic a_bit, input logic b_bit, input logic c_bit);
        logic [2:0] s;
        s            = '0;
        s[SEL_A_BIT] = a_bit;
        s[SEL_B_BIT] = b_bit;
        s[SEL_C_BIT] = c_bit;
        return s;
    endfunction

endpackage

// File: rtl/mux_8_1.sv
// Plain 8:1 multiplexer; with a constant data vector it acts as a 3-input LUT.
module mux_8_1 (
    input  logic [7:0] I,
    input  logic [2:0] s,
    output logic       y
);

    assign y = I[s];

endmodule

// File: rtl/serial_adder_mux.sv
// Bit-serial WIDTH-bit adder: one sum/carry bit per cycle from two LUT muxes,
// wrapped in a start/busy/done handshake with registered sum and cout.
module serial_adder_mux
    import adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_reg;
    logic [WIDTH-1:0] a_sr_reg;
    logic [WIDTH-1:0] b_sr_reg;
    logic [WIDTH-1:0] res_sr_reg;
    logic             c_reg;
    logic [CW-1:0]    cnt_reg;

    logic [2:0]       sel;
    logic             s_bit;
    logic             c_bit;
    logic [WIDTH-1:0] res_next;

    assign sel = make_sel(a_sr_reg[0], b_sr_reg[0], c_reg);

    mux_8_1 u_sum_mux (
        .I (SUM_LUT),
        .s (sel),
        .y (s_bit)
    );

    mux_8_1 u_carry_mux (
        .I (CARRY_LUT),
        .s (sel),
        .y (c_bit)
    );

    // New sum bit enters at the MSB so the LSB ends up at bit 0 after WIDTH shifts.
    assign res_next = WIDTH'({s_bit, res_sr_reg} >> 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            a_sr_reg   <= '0;
            b_sr_reg   <= '0;
            res_sr_reg <= '0;
            c_reg      <= 1'b0;
            cnt_reg    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            sum        <= '0;
            cout       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr_reg  <= a;
                        b_sr_reg  <= b;
                        c_reg     <= cin;
                        cnt_reg   <= '0;
                        busy      <= 1'b1;
                        state_reg <= RUN;
                    end else begin
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                RUN: begin
                    a_sr_reg   <= a_sr_reg >> 1;
                    b_sr_reg   <= b_sr_reg >> 1;
                    res_sr_reg <= res_next;
                    c_reg      <= c_bit;
                    cnt_reg    <= cnt_reg + 1'b1;
                    // Outputs are committed only here, never bit by bit.
                    if (cnt_reg == LAST_BIT) begin
                        sum       <= res_next;
                        cout      <= c_bit;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                default: begin
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_mux.sv
// Scoreboard bench for serial_adder_mux at WIDTH=8 and WIDTH=1.
// Expected results come from plain a+b+cin arithmetic and spec timing.
module tb_serial_adder_mux;

    typedef struct {
        logic [8:0] val;
        int         acc;
        int         due;
    } exp_t;

    logic       clk;
    logic       rst;

    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;

    logic       start1, cin1, busy1, done1, cout1;
    logic [0:0] a1, b1, sum1;

    int   cyc;
    int   n_checks;
    int   n_fail;
    bit   chk_en;

    exp_t q8[$];
    exp_t q1[$];
    logic [8:0] held8;
    logic [1:0] held1;
    int   n_exp8, n_exp1, n_seen8, n_seen1;

    serial_adder_mux #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    serial_adder_mux #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Per-cycle monitors: done exactly at the due cycle, busy in the run window,
    // and outputs holding the last completed result otherwise.
    always @(negedge clk) begin
        if (chk_en) begin
            bit due_now;
            bit busy_e;
            due_now = (q8.size() > 0) && (cyc == q8[0].due);
            busy_e  = (q8.size() > 0) && (cyc >= q8[0].acc) && (cyc < q8[0].due);
            if (done8 === 1'b1) n_seen8++;
            check("done8", done8, due_now);
            check("busy8", busy8, busy_e);
            if (due_now) begin
                held8 = q8[0].val;
                void'(q8.pop_front());
            end
            check("result8", {cout8, sum8}, held8);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            bit due_now;
            bit busy_e;
            due_now = (q1.size() > 0) && (cyc == q1[0].due);
            busy_e  = (q1.size() > 0) && (cyc >= q1[0].acc) && (cyc < q1[0].due);
            if (done1 === 1'b1) n_seen1++;
            check("done1", done1, due_now);
            check("busy1", busy1, busy_e);
            if (due_now) begin
                held1 = q1[0].val[1:0];
                void'(q1.pop_front());
            end
            check("result1", {cout1, sum1}, held1);
        end
    end

    // Called at a negedge where the DUT can accept; returns at the negedge
    // ending the DONE cycle plus gap idle cycles. poke re-pulses start mid-run.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                       input logic [8:0] expv, input int gap, input bit poke);
        exp_t e;
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        @(posedge clk);
        #1;
        e.val = expv; e.acc = cyc; e.due = cyc + 8;
        q8.push_back(e);
        n_exp8++;
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (poke && i == 2) begin
                start8 = 1'b1; a8 = 8'hAA;
            end else begin
                start8 = 1'b0;
            end
        end
        repeat (gap) @(negedge clk);
    endtask

    task automatic op1(input logic a, input logic b, input logic c, input int gap);
        exp_t e;
        a1 = a; b1 = b; cin1 = c; start1 = 1'b1;
        @(posedge clk);
        #1;
        e.val = 9'(a) + 9'(b) + 9'(c);
        e.acc = cyc; e.due = cyc + 1;
        q1.push_back(e);
        n_exp1++;
        start1 = 1'b0;
        repeat (2) @(negedge clk);
        repeat (gap) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy8"}, busy8, 1'b0);
        check({tag, "_done8"}, done8, 1'b0);
        check({tag, "_sum8"},  sum8,  8'h00);
        check({tag, "_cout8"}, cout8, 1'b0);
        check({tag, "_busy1"}, busy1, 1'b0);
        check({tag, "_done1"}, done1, 1'b0);
        check({tag, "_res1"},  {cout1, sum1}, 2'b00);
    endtask

    initial begin
        logic [8:0] model;
        logic [7:0] ra, rb;
        logic       rc;
        logic [2:0] v;
        cyc = 0; n_checks = 0; n_fail = 0; chk_en = 1'b0;
        held8 = '0; held1 = '0;
        n_exp8 = 0; n_exp1 = 0; n_seen8 = 0; n_seen1 = 0;
        rst = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;

        // Asynchronous reset takes effect between clock edges.
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        repeat (5) @(negedge clk);

        // WIDTH=1 exhaustive.
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            op1(v[2], v[1], v[0], i % 2);
        end

        // WIDTH=8 directed.
        op8(8'h3C, 8'h5A, 1'b0, 9'h096, 1, 1'b0);
        op8(8'hFF, 8'h01, 1'b0, 9'h100, 1, 1'b0);
        op8(8'h00, 8'h00, 1'b1, 9'h001, 0, 1'b0);
        op8(8'hFF, 8'hFF, 1'b1, 9'h1FF, 2, 1'b0);
        op8(8'h10, 8'h20, 1'b0, 9'h030, 0, 1'b1);
        op8(8'h01, 8'h02, 1'b0, 9'h003, 2, 1'b0);

        // Reset four RUN edges into an operation: no done, outputs cleared.
        begin
            exp_t e;
            a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
            @(posedge clk);
            #1;
            e.val = 9'h080; e.acc = cyc; e.due = cyc + 8;
            q8.push_back(e);
            n_exp8++;
            start8 = 1'b0;
            repeat (4) @(posedge clk);
            #2 rst = 1'b1;
            n_exp8 = n_exp8 - q8.size();
            q8.delete();
            held8 = '0;
            held1 = '0;
            #1 check_reset_outputs("midrun_rst");
            @(negedge clk);
            rst = 1'b0;
            repeat (12) @(negedge clk);
        end
        op8(8'h7F, 8'h01, 1'b0, 9'h080, 1, 1'b0);

        // Randomized sweep against the arithmetic model.
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            model = 9'(ra) + 9'(rb) + 9'(rc);
            op8(ra, rb, rc, model, int'($urandom_range(0, 2)), ($urandom_range(0, 9) == 0));
        end

        repeat (12) @(negedge clk);
        #1;
        check("q8_drained", q8.size(), 0);
        check("q1_drained", q1.size(), 0);
        check("done_count8", n_seen8, n_exp8);
        check("done_count1", n_seen1, n_exp1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion (cycle %0d)", cyc);
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
